// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the memory port arbiter.
//   - arb_state_e : arbiter FSM encoding (ARB, LOCK0, LOCK1)
//   - PORT_CPU / PORT_DMA : bit positions of the two ports in req/gnt/lock/we/rvalid
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

  localparam int PORT_CPU = 0;
  localparam int PORT_DMA = 1;

endpackage

// File: rtl/arb_rr_pick2.sv
// arb_rr_pick2: combinational two-way round-robin picker.
// Ports:
//   req    in  [1:0]  request vector (bit0 = CPU, bit1 = DMA)
//   rr_ptr in         preferred port when both request (0 = CPU, 1 = DMA)
//   pick   out [1:0]  one-hot pick, zero when nobody requests
module arb_rr_pick2 (
  input  logic [1:0] req,
  input  logic       rr_ptr,
  output logic [1:0] pick
);

  always_comb begin
    pick = 2'b00;
    unique case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = rr_ptr ? 2'b10 : 2'b01;
      default: pick = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the CPU (port 0)
// and a DMA/program loader (port 1). Round-robin arbitration with an optional
// per-port burst lock, registered memory-side address/data/strobe and a fixed
// two-cycle read return.
//
// Optional feature macro: MEM_ARB_STATS_EN builds saturating grant/conflict
// counters; without it the stat_* outputs are tied to zero.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req/lock/we [1:0]   per-port request, burst lock, write enable
//   addr0/addr1         per-port word address (AW)
//   wdata0/wdata1       per-port write data (DW)
//   gnt [1:0]           combinational one-hot grant
//   rvalid [1:0]        registered one-hot read-data valid
//   rdata               shared read data, qualified by rvalid
//   mem_write/mem_addr/to_mem   registered memory-side strobe/address/data
//   from_mem            memory read data (combinational from mem_addr)
//   stat_gnt0/1, stat_confl     statistics counters (CNT_W)
//   dbg_state           current FSM state
//
// Handshake: a port raises req[p] with addr/we/wdata valid and holds them
// until it sees gnt[p]=1 in the same cycle; that cycle is the transfer.
// A read's data arrives exactly two cycles later with rvalid[p]=1 for one cycle.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = 12,
  parameter int DW       = 32,
  parameter int MAX_LOCK = 8,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [1:0]       lock,
  input  logic [1:0]       we,
  input  logic [AW-1:0]    addr0,
  input  logic [AW-1:0]    addr1,
  input  logic [DW-1:0]    wdata0,
  input  logic [DW-1:0]    wdata1,
  output logic [1:0]       gnt,
  output logic [1:0]       rvalid,
  output logic [DW-1:0]    rdata,
  output logic             mem_write,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    to_mem,
  input  logic [DW-1:0]    from_mem,
  output logic [CNT_W-1:0] stat_gnt0,
  output logic [CNT_W-1:0] stat_gnt1,
  output logic [CNT_W-1:0] stat_confl,
  output logic [1:0]       dbg_state
);

  localparam int LCW = $clog2(MAX_LOCK + 1);

  arb_state_e       state_q, state_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic [LCW-1:0]   lock_cnt_q, lock_cnt_d;
  logic [1:0]       pick;
  logic [1:0]       gnt_c;
  logic             gnt_p;    // index of the granted port (valid when |gnt_c)
  logic             lock_p;   // port owning the lock in LOCK0/LOCK1
  logic             mem_write_q;
  logic [AW-1:0]    mem_addr_q;
  logic [DW-1:0]    to_mem_q;
  logic [1:0]       rd_pend_q;  // read accessing the memory this cycle
  logic [1:0]       rvalid_q;
  logic [DW-1:0]    rdata_q;

  arb_rr_pick2 u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .pick   (pick)
  );

  assign gnt_p  = gnt_c[PORT_DMA];
  assign lock_p = (state_q == LOCK1);

  // Output process: grant decode. Held at zero while reset is asserted.
  always_comb begin
    gnt_c = 2'b00;
    unique case (state_q)
      ARB:     gnt_c = pick;
      LOCK0:   gnt_c = {1'b0, req[PORT_CPU]};
      LOCK1:   gnt_c = {req[PORT_DMA], 1'b0};
      default: gnt_c = 2'b00;
    endcase
    if (rst) gnt_c = 2'b00;
  end

  // Next-state process.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_cnt_d = lock_cnt_q;
    unique case (state_q)
      ARB: begin
        if (|gnt_c) begin
          rr_ptr_d = ~gnt_p;
          // With MAX_LOCK==1 the first grant already exhausts the lock budget.
          if (lock[gnt_p] && (MAX_LOCK > 1)) begin
            state_d    = gnt_p ? LOCK1 : LOCK0;
            lock_cnt_d = LCW'(1);
          end
        end
      end
      LOCK0, LOCK1: begin
        if (!req[lock_p]) begin
          state_d    = ARB;
          lock_cnt_d = '0;
        end else begin
          // rr_ptr already points away from the owner, so a forced release
          // hands the next contended cycle to the other port.
          rr_ptr_d   = ~lock_p;
          lock_cnt_d = lock_cnt_q + LCW'(1);
          if (!lock[lock_p] || (lock_cnt_d == LCW'(MAX_LOCK))) begin
            state_d    = ARB;
            lock_cnt_d = '0;
          end
        end
      end
      default: begin
        state_d    = ARB;
        lock_cnt_d = '0;
      end
    endcase
  end

  // State register plus memory-side and read-return pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB;
      rr_ptr_q    <= 1'b0;
      lock_cnt_q  <= '0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      to_mem_q    <= '0;
      rd_pend_q   <= 2'b00;
      rvalid_q    <= 2'b00;
      rdata_q     <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_cnt_q <= lock_cnt_d;
      if (|gnt_c) begin
        mem_write_q <= we[gnt_p];
        mem_addr_q  <= gnt_p ? addr1 : addr0;
        to_mem_q    <= gnt_p ? wdata1 : wdata0;
      end else begin
        mem_write_q <= 1'b0;
      end
      rd_pend_q <= gnt_c & ~we;
      rvalid_q  <= rd_pend_q;
      if (|rd_pend_q) rdata_q <= from_mem;
    end
  end

  assign gnt       = gnt_c;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  // A write registered just before reset must not reach the array.
  assign mem_write = mem_write_q & ~rst;
  assign mem_addr  = mem_addr_q;
  assign to_mem    = to_mem_q;
  assign dbg_state = state_q;

`ifdef MEM_ARB_STATS_EN
  logic [CNT_W-1:0] stat_gnt0_q, stat_gnt1_q, stat_confl_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_gnt0_q  <= '0;
      stat_gnt1_q  <= '0;
      stat_confl_q <= '0;
    end else begin
      if (gnt_c[PORT_CPU] && (stat_gnt0_q != '1)) stat_gnt0_q <= stat_gnt0_q + CNT_W'(1);
      if (gnt_c[PORT_DMA] && (stat_gnt1_q != '1)) stat_gnt1_q <= stat_gnt1_q + CNT_W'(1);
      if ((req == 2'b11) && (stat_confl_q != '1)) stat_confl_q <= stat_confl_q + CNT_W'(1);
    end
  end

  assign stat_gnt0  = stat_gnt0_q;
  assign stat_gnt1  = stat_gnt1_q;
  assign stat_confl = stat_confl_q;
`else
  assign stat_gnt0  = '0;
  assign stat_gnt1  = '0;
  assign stat_confl = '0;
`endif

endmodule
